// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid, synchronous flush.
// Empty slots present all-zero control so downstream stages see a NOP bubble.
module pipe_stage_buf #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              emit;

    assign accept    = in_valid & in_ready;
    assign emit      = main_vld & out_ready;
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_data;

    if (SKID != 0) begin : g_skid
        logic              skid_vld;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;
        logic              rdy_q;

        // rdy_q tracks !skid_vld so in_ready never depends on out_ready.
        assign in_ready = rdy_q;
        assign count    = {1'b0, main_vld} + {1'b0, skid_vld};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
                main_data <= '0;
                skid_vld  <= 1'b0;
                skid_ctrl <= '0;
                skid_data <= '0;
                rdy_q     <= 1'b1;
            end else if (flush) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
                skid_vld  <= 1'b0;
                skid_ctrl <= '0;
                rdy_q     <= 1'b1;
                if (CLEAR_DATA != 0) begin
                    main_data <= '0;
                    skid_data <= '0;
                end
            end else if (skid_vld) begin
                if (emit) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                    skid_vld  <= 1'b0;
                    rdy_q     <= 1'b1;
                end
            end else if (accept && (!main_vld || emit)) begin
                main_vld  <= 1'b1;
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (accept) begin
                skid_vld  <= 1'b1;
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
                rdy_q     <= 1'b0;
            end else if (emit) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
            end
        end
    end else begin : g_reg
        assign in_ready = !main_vld | out_ready;
        assign count    = {1'b0, main_vld};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
                main_data <= '0;
            end else if (flush) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
                if (CLEAR_DATA != 0) main_data <= '0;
            end else if (accept) begin
                main_vld  <= 1'b1;
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (emit) begin
                main_vld  <= 1'b0;
                main_ctrl <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance and a single-register/clear-data instance share stimulus,
// each checked every cycle against a FIFO-of-beats model plus a few literal expectations.
module tb_pipe_stage_buf;

    typedef struct {
        logic [7:0]  c;
        logic [31:0] d;
    } beat_t;

    logic        clk, reset, flush, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0]  out_ctrl_a, out_ctrl_b;
    logic [31:0] out_data_a, out_data_b;
    logic [1:0]  count_a, count_b;

    int checks = 0;
    int errors = 0;

    beat_t       qa[$];
    beat_t       qb[$];
    logic [31:0] hold_a, hold_b;

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .SKID(1), .CLEAR_DATA(0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
        .out_data(out_data_a), .count(count_a)
    );

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .SKID(0), .CLEAR_DATA(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
        .out_data(out_data_b), .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [7:0]  ec;
        logic [31:0] ed;
        #1;
        ec = 8'h0;
        ed = hold_a;
        if (qa.size() > 0) begin
            ec = qa[0].c;
            ed = qa[0].d;
        end
        chk("a_valid", 32'(out_valid_a), 32'(qa.size() > 0));
        chk("a_ctrl",  32'(out_ctrl_a),  32'(ec));
        chk("a_data",  out_data_a,       ed);
        chk("a_count", 32'(count_a),     32'(qa.size()));
        chk("a_ready", 32'(in_ready_a),  32'(qa.size() < 2));
        ec = 8'h0;
        ed = hold_b;
        if (qb.size() > 0) begin
            ec = qb[0].c;
            ed = qb[0].d;
        end
        chk("b_valid", 32'(out_valid_b), 32'(qb.size() > 0));
        chk("b_ctrl",  32'(out_ctrl_b),  32'(ec));
        chk("b_data",  out_data_b,       ed);
        chk("b_count", 32'(count_b),     32'(qb.size()));
        chk("b_ready", 32'(in_ready_b),  32'(qb.size() == 0 || out_ready));
    endtask

    // One cycle: check outputs, then advance the beat queues by the handshake rules.
    task automatic tick();
        bit    acc_a, em_a, acc_b, em_b, fl;
        beat_t bt;
        compare();
        acc_a = in_valid && (qa.size() < 2);
        em_a  = (qa.size() > 0) && out_ready;
        acc_b = in_valid && (qb.size() == 0 || out_ready);
        em_b  = (qb.size() > 0) && out_ready;
        fl    = flush;
        bt.c  = in_ctrl;
        bt.d  = in_data;
        @(posedge clk);
        if (fl) begin
            qa.delete();
            qb.delete();
            hold_b = 32'h0;
        end else begin
            if (em_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(bt);
            if (em_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(bt);
        end
        if (qa.size() > 0) hold_a = qa[0].d;
        if (qb.size() > 0) hold_b = qb[0].d;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 8'h0, 32'h0, 1'b0);
        hold_a = 32'h0;
        hold_b = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_valid", 32'(out_valid_a), 32'h0);
        chk("rst_a_count", 32'(count_a),     32'h0);
        chk("rst_a_ready", 32'(in_ready_a),  32'h1);
        chk("rst_b_data",  out_data_b,       32'h0);
        reset = 1'b0;
        @(negedge clk);
        tick();

        // T1: single beat, one-cycle latency
        drive(1'b1, 8'hA5, 32'h1111_0001, 1'b1);
        tick();
        drive(1'b0, 8'h00, 32'h0, 1'b1);
        #1;
        chk("t1_a_ctrl",  32'(out_ctrl_a), 32'hA5);
        chk("t1_a_data",  out_data_a,      32'h1111_0001);
        chk("t1_a_count", 32'(count_a),    32'h1);
        tick();
        tick();

        // T2: stall fills skid; release drains in order
        drive(1'b1, 8'hC1, 32'hC1C1_0001, 1'b0);
        tick();
        drive(1'b1, 8'hC2, 32'hC2C2_0002, 1'b0);
        tick();
        drive(1'b0, 8'h00, 32'h0, 1'b0);
        tick();
        #1;
        chk("t2_a_count", 32'(count_a),    32'h2);
        chk("t2_a_ready", 32'(in_ready_a), 32'h0);
        chk("t2_a_ctrl",  32'(out_ctrl_a), 32'hC1);
        out_ready = 1'b1;
        tick();
        #1;
        chk("t2_a_ctrl2", 32'(out_ctrl_a), 32'hC2);
        tick();
        tick();

        // T3: 16-beat stream at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 32'(i * 32'h101), 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 32'h0, 1'b1);
        tick();
        tick();

        // T4: flush a full stage together with an incoming beat
        drive(1'b1, 8'hC1, 32'hC1C1_0001, 1'b0);
        tick();
        drive(1'b1, 8'hC2, 32'hC2C2_0002, 1'b0);
        tick();
        drive(1'b1, 8'hC3, 32'hC3C3_0003, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("t4_a_valid", 32'(out_valid_a), 32'h0);
        chk("t4_a_count", 32'(count_a),     32'h0);
        chk("t4_a_ready", 32'(in_ready_a),  32'h1);
        chk("t4_b_data",  out_data_b,       32'h0);
        out_ready = 1'b1;
        tick();
        tick();

        // flush coinciding with emit, then flush while empty
        drive(1'b1, 8'h77, 32'h7777_0007, 1'b1);
        tick();
        drive(1'b0, 8'h00, 32'h0, 1'b1);
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        tick();

        // T5: async reset between edges with the skid full
        drive(1'b1, 8'hD1, 32'hD1D1_0001, 1'b0);
        tick();
        drive(1'b1, 8'hD2, 32'hD2D2_0002, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_a_valid", 32'(out_valid_a), 32'h0);
        chk("t5_a_ctrl",  32'(out_ctrl_a),  32'h0);
        chk("t5_a_data",  out_data_a,       32'h0);
        chk("t5_a_count", 32'(count_a),     32'h0);
        chk("t5_a_ready", 32'(in_ready_a),  32'h1);
        qa.delete();
        qb.delete();
        hold_a = 32'h0;
        hold_b = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // T6: random handshake traffic with occasional flush
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
